// File: rtl/y86_pipe_stage_reg_pkg.sv
// Shared types and helpers for the Y86 pipeline stage register.
// Holds the stage-mode encoding and the stall/bubble priority decode.
package y86_pipe_stage_reg_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_LOAD   = 2'd0,
        MODE_STALL  = 2'd1,
        MODE_BUBBLE = 2'd2
    } stage_mode_e;

    // A bubble overrides a stall; otherwise the stage either holds or loads.
    function automatic stage_mode_e decode_mode(input logic stall, input logic bubble);
        stage_mode_e mode;
        if (bubble) begin
            mode = MODE_BUBBLE;
        end else if (stall) begin
            mode = MODE_STALL;
        end else begin
            mode = MODE_LOAD;
        end
        return mode;
    endfunction

endpackage

// File: rtl/y86_pipe_stage_reg_sat_counter.sv
// Saturating event counter with synchronous clear.
// Ports: clk_i, rst_n_i (async active-low), clr_i (sync clear, beats inc_i),
//        inc_i (count one event), cnt_o (count, sticks at all-ones).
module sat_counter
    import y86_pipe_stage_reg_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    // Clear wins over a same-cycle increment; never wrap past all-ones.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/y86_pipe_stage_reg.sv
// Generic Y86 pipeline stage register with stall/bubble control and
// saturating stall/bubble performance counters.
// Ports: clk_i, rst_n_i (async active-low); stall_i, bubble_i (bubble wins);
//        valid_i, stat_i, data_i (upstream slot); cnt_clr_i (clear counters);
//        stat_o, data_o, valid_o, is_bubble_o (registered slot);
//        stall_cnt_o, bubble_cnt_o (saturating counters).
module y86_pipe_stage_reg
    import y86_pipe_stage_reg_pkg::*;
#(
    parameter int unsigned        DATA_W           = 64,
    parameter int unsigned        STAT_W           = 3,
    parameter logic [DATA_W-1:0]  BUBBLE_PAYLOAD   = '0,
    parameter logic [STAT_W-1:0]  STAT_RST         = STAT_W'(1),
    parameter bit                 BUBBLE_KEEP_STAT = 1'b1,
    parameter logic [STAT_W-1:0]  STAT_BUBBLE      = STAT_W'(1),
    parameter int unsigned        CNT_W            = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              stall_i,
    input  logic              bubble_i,
    input  logic              valid_i,
    input  logic [STAT_W-1:0] stat_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              cnt_clr_i,
    output logic [STAT_W-1:0] stat_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              is_bubble_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    stage_mode_e       mode;
    logic [DATA_W-1:0] data_nxt;
    logic [STAT_W-1:0] stat_nxt;
    logic              valid_nxt;
    logic              bub_nxt;
    logic              stall_inc;
    logic              bubble_inc;

    // Next-slot selection; defaults hold the current contents.
    always_comb begin
        mode       = decode_mode(stall_i, bubble_i);
        data_nxt   = data_o;
        stat_nxt   = stat_o;
        valid_nxt  = valid_o;
        bub_nxt    = is_bubble_o;
        stall_inc  = 1'b0;
        bubble_inc = 1'b0;
        case (mode)
            MODE_BUBBLE: begin
                data_nxt   = BUBBLE_PAYLOAD;
                stat_nxt   = BUBBLE_KEEP_STAT ? stat_i : STAT_BUBBLE;
                valid_nxt  = 1'b0;
                bub_nxt    = 1'b1;
                bubble_inc = 1'b1;
            end
            MODE_STALL: begin
                stall_inc = 1'b1;
            end
            default: begin
                // A load with valid_i low still latches data: a squashed slot, not a bubble.
                data_nxt  = data_i;
                stat_nxt  = stat_i;
                valid_nxt = valid_i;
                bub_nxt   = 1'b0;
            end
        endcase
    end

    // Slot register; reset leaves the stage looking like an injected bubble.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_o      <= BUBBLE_PAYLOAD;
            stat_o      <= STAT_RST;
            valid_o     <= 1'b0;
            is_bubble_o <= 1'b1;
        end else begin
            data_o      <= data_nxt;
            stat_o      <= stat_nxt;
            valid_o     <= valid_nxt;
            is_bubble_o <= bub_nxt;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (cnt_clr_i),
        .inc_i   (stall_inc),
        .cnt_o   (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (cnt_clr_i),
        .inc_i   (bubble_inc),
        .cnt_o   (bubble_cnt_o)
    );

endmodule
